// File: rtl/ttc_lite_pkg2.sv
// Shared constants for the lite TTC timer/counter: control-register bit positions,
// default counter width and the prescaler terminal-count helper.
package ttc_lite_pkg2;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  // clk_ctrl_reg2 fields
  localparam int PRESC_EN      = 0;
  localparam int PRESC_SEL_LSB = 1;
  localparam int PRESC_SEL_W   = 4;
  localparam int EXT_SEL       = 5;
  localparam int EXT_EDGE      = 6;

  // cntr_ctrl2 fields
  localparam int DIS   = 0;
  localparam int INTV  = 1;
  localparam int DEC   = 2;
  localparam int MATCH = 3;

  localparam int PRESC_W = 16;

  // Terminal count for select N is 2^(N+1)-1, built as a right shift of all-ones.
  function automatic logic [PRESC_W-1:0] presc_terminal(input logic [PRESC_SEL_W-1:0] sel);
    return {PRESC_W{1'b1}} >> (4'd15 - sel);
  endfunction

endpackage

// File: rtl/ttc_ext_clk_sync2.sv
// Synchronises the asynchronous external clock pin and produces a one-cycle
// pulse on the selected edge (0 = rising, 1 = falling).
module ttc_ext_clk_sync2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk2,
  input  logic n_p_reset2,
  input  logic i_ext_clk,
  input  logic i_edge_sel,
  output logic o_edge_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk2 or negedge n_p_reset2) begin
    if (!n_p_reset2) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_clk};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign o_edge_pulse = i_edge_sel ? (~w_sync & r_prev) : (w_sync & ~r_prev);

endmodule

// File: rtl/ttc_timer_counter_lite2.sv
// TTC counter consumer: source select, prescaler, registered count tick, 16-bit
// up/down interval/free-run counter and single-cycle interval/match/overflow pulses.
module ttc_timer_counter_lite2
  import ttc_lite_pkg2::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk2,
  input  logic             n_p_reset2,
  input  logic [6:0]       clk_ctrl_reg2,
  input  logic             count_en2,
  input  logic [3:0]       cntr_ctrl2,
  input  logic [CNT_W-1:0] interval_reg2,
  input  logic [CNT_W-1:0] match_value2,
  input  logic             ext_clk2,
  output logic             count_tick2,
  output logic [CNT_W-1:0] counter_val2,
  output logic             interval_intr2,
  output logic             match_intr2,
  output logic             overflow_intr2
);

  localparam logic [CNT_W-1:0] W_MAX = '1;

  logic               w_edge;
  logic               w_src_tick;
  logic               w_presc_en;
  logic               w_dis;
  logic               w_intv;
  logic               w_dec;
  logic [PRESC_W-1:0] w_presc_term;
  logic               w_presc_at_term;
  logic               w_presc_tick;
  logic               w_update;
  logic [CNT_W-1:0]   w_next;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_restart_val;

  logic [PRESC_W-1:0] r_presc_cnt;
  logic               r_count_tick;
  logic [CNT_W-1:0]   r_counter;
  logic               r_intv_intr;
  logic               r_match_intr;
  logic               r_ovf_intr;

  ttc_ext_clk_sync2 #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .pclk2        (pclk2),
    .n_p_reset2   (n_p_reset2),
    .i_ext_clk    (ext_clk2),
    .i_edge_sel   (clk_ctrl_reg2[EXT_EDGE]),
    .o_edge_pulse (w_edge)
  );

  assign w_src_tick      = clk_ctrl_reg2[EXT_SEL] ? w_edge : 1'b1;
  assign w_presc_en      = clk_ctrl_reg2[PRESC_EN];
  assign w_dis           = cntr_ctrl2[DIS];
  assign w_intv          = cntr_ctrl2[INTV];
  assign w_dec           = cntr_ctrl2[DEC];
  assign w_presc_term    = presc_terminal(clk_ctrl_reg2[PRESC_SEL_LSB +: PRESC_SEL_W]);
  assign w_presc_at_term = (r_presc_cnt == w_presc_term);
  assign w_presc_tick    = w_src_tick & (~w_presc_en | w_presc_at_term);
  assign w_update        = r_count_tick & count_en2 & ~w_dis;

  // A count above a newly lowered terminal value simply rolls through 0xFFFF to 0.
  always_ff @(posedge pclk2 or negedge n_p_reset2) begin
    if (!n_p_reset2) begin
      r_presc_cnt  <= '0;
      r_count_tick <= 1'b0;
    end else begin
      r_count_tick <= w_presc_tick & count_en2 & ~w_dis;
      if (!count_en2)
        r_presc_cnt <= '0;
      else if (!w_dis && w_presc_en && w_src_tick)
        r_presc_cnt <= w_presc_at_term ? '0 : r_presc_cnt + 1'b1;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_counter;
    w_wrap = 1'b0;
    if (w_dec) begin
      if (r_counter == '0) begin
        w_wrap = 1'b1;
        w_next = w_intv ? interval_reg2 : W_MAX;
      end else begin
        w_next = r_counter - 1'b1;
      end
    end else begin
      if (r_counter == (w_intv ? interval_reg2 : W_MAX)) begin
        w_wrap = 1'b1;
        w_next = '0;
      end else begin
        w_next = r_counter + 1'b1;
      end
    end
  end

  assign w_restart_val = !w_dec ? '0 : (w_intv ? interval_reg2 : W_MAX);

  // Restart outranks everything: reload, and suppress any tick already in flight.
  always_ff @(posedge pclk2 or negedge n_p_reset2) begin
    if (!n_p_reset2) begin
      r_counter    <= '0;
      r_intv_intr  <= 1'b0;
      r_match_intr <= 1'b0;
      r_ovf_intr   <= 1'b0;
    end else if (!count_en2) begin
      r_counter    <= w_restart_val;
      r_intv_intr  <= 1'b0;
      r_match_intr <= 1'b0;
      r_ovf_intr   <= 1'b0;
    end else begin
      r_intv_intr  <= w_update & w_wrap & w_intv;
      r_ovf_intr   <= w_update & w_wrap & ~w_intv;
      r_match_intr <= w_update & cntr_ctrl2[MATCH] & (w_next == match_value2);
      if (w_update)
        r_counter <= w_next;
    end
  end

  assign count_tick2    = r_count_tick;
  assign counter_val2   = r_counter;
  assign interval_intr2 = r_intv_intr;
  assign match_intr2    = r_match_intr;
  assign overflow_intr2 = r_ovf_intr;

endmodule

// File: tb/tb_ttc_timer_counter_lite2.sv
// Directed bench for ttc_timer_counter_lite2; expected values are hand-derived
// from the cycle timing (tick one cycle after source tick, value/pulses one later).
module tb_ttc_timer_counter_lite2;

  logic        pclk2 = 1'b0;
  logic        n_p_reset2;
  logic [6:0]  clk_ctrl_reg2;
  logic        count_en2;
  logic [3:0]  cntr_ctrl2;
  logic [15:0] interval_reg2;
  logic [15:0] match_value2;
  logic        ext_clk2;
  logic        count_tick2;
  logic [15:0] counter_val2;
  logic        interval_intr2;
  logic        match_intr2;
  logic        overflow_intr2;

  int n_tests = 0;
  int n_fail  = 0;

  ttc_timer_counter_lite2 #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .pclk2          (pclk2),
    .n_p_reset2     (n_p_reset2),
    .clk_ctrl_reg2  (clk_ctrl_reg2),
    .count_en2      (count_en2),
    .cntr_ctrl2     (cntr_ctrl2),
    .interval_reg2  (interval_reg2),
    .match_value2   (match_value2),
    .ext_clk2       (ext_clk2),
    .count_tick2    (count_tick2),
    .counter_val2   (counter_val2),
    .interval_intr2 (interval_intr2),
    .match_intr2    (match_intr2),
    .overflow_intr2 (overflow_intr2)
  );

  always #5 pclk2 = ~pclk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge pclk2);
    #1;
  endtask

  task automatic restart();
    count_en2 = 1'b0;
    step(1);
    count_en2 = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_v;

    n_p_reset2    = 1'b0;
    clk_ctrl_reg2 = 7'h00;
    count_en2     = 1'b0;
    cntr_ctrl2    = 4'h0;
    interval_reg2 = 16'd0;
    match_value2  = 16'd0;
    ext_clk2      = 1'b1;
    step(3);
    check("rst_val", counter_val2, 16'h0);
    check("rst_tick", count_tick2, 1'b0);
    n_p_reset2 = 1'b1;

    // Reset mid-count at 0x0123
    restart();
    step(16'h124);
    check("pre_rst_val", counter_val2, 16'h0123);
    n_p_reset2 = 1'b0;
    #1;
    check("async_rst_val", counter_val2, 16'h0);
    check("async_rst_tick", count_tick2, 1'b0);
    check("async_rst_intr", {interval_intr2, match_intr2, overflow_intr2}, 3'b000);
    #2 n_p_reset2 = 1'b1;
    step(1);
    check("resume_tick", count_tick2, 1'b1);
    check("resume_val0", counter_val2, 16'h0);
    step(1);
    check("resume_val1", counter_val2, 16'h1);

    // Up interval mode, interval=5: 0..5,0 with a pulse on each wrap
    cntr_ctrl2    = 4'h2;
    interval_reg2 = 16'd5;
    restart();
    for (int k = 1; k <= 13; k++) begin
      step(1);
      check($sformatf("upintv_val_k%0d", k), counter_val2, 16'((k - 1) % 6));
      check($sformatf("upintv_intr_k%0d", k), interval_intr2, (k > 1 && (k - 1) % 6 == 0));
    end

    // Up interval mode with interval=0: stays at 0, pulse every tick
    interval_reg2 = 16'd0;
    restart();
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("intv0_val_k%0d", k), counter_val2, 16'h0);
      check($sformatf("intv0_intr_k%0d", k), interval_intr2, (k >= 2));
    end

    // Prescale /4, up free-run from 0xFFFE across overflow
    cntr_ctrl2 = 4'h4;
    restart();
    step(2);
    check("preset_fffe", counter_val2, 16'hFFFE);
    cntr_ctrl2    = 4'h1;
    clk_ctrl_reg2 = 7'h03;
    step(1);
    check("dis_hold_val", counter_val2, 16'hFFFE);
    check("dis_no_tick", count_tick2, 1'b0);
    cntr_ctrl2 = 4'h0;
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp_v = (k < 5) ? 16'hFFFE : (k < 9) ? 16'hFFFF : (k < 13) ? 16'h0 : 16'h1;
      check($sformatf("presc_val_k%0d", k), counter_val2, exp_v);
      check($sformatf("presc_tick_k%0d", k), count_tick2, (k % 4 == 0));
      check($sformatf("presc_ovf_k%0d", k), overflow_intr2, (k == 9));
    end
    clk_ctrl_reg2 = 7'h00;

    // Down interval mode, interval=3, match on 1
    cntr_ctrl2    = 4'hE;
    interval_reg2 = 16'd3;
    match_value2  = 16'd1;
    restart();
    for (int k = 1; k <= 10; k++) begin
      step(1);
      exp_v = 16'(3 - ((k - 1) % 4));
      check($sformatf("dn_val_k%0d", k), counter_val2, exp_v);
      check($sformatf("dn_match_k%0d", k), match_intr2, (k > 1 && exp_v == 16'd1));
      check($sformatf("dn_intv_k%0d", k), interval_intr2, (k > 1 && exp_v == 16'd3));
    end

    // One-cycle restart at 0x0040 during down count
    cntr_ctrl2    = 4'h6;
    interval_reg2 = 16'h0050;
    restart();
    step(17);
    check("dn_at_40", counter_val2, 16'h0040);
    count_en2    = 1'b0;
    cntr_ctrl2   = 4'hE;
    match_value2 = 16'h0050;
    step(1);
    check("rs_reload", counter_val2, 16'h0050);
    check("rs_no_tick", count_tick2, 1'b0);
    check("rs_no_intr", {interval_intr2, match_intr2, overflow_intr2}, 3'b000);
    cntr_ctrl2 = 4'h4;
    step(1);
    check("rs_freerun_reload", counter_val2, 16'hFFFF);

    // External falling-edge source, 10 periods of 8 cycles
    clk_ctrl_reg2 = 7'h60;
    cntr_ctrl2    = 4'h0;
    restart();
    step(2);
    check("ext_idle", counter_val2, 16'h0);
    ext_clk2 = 1'b0;
    step(3);
    check("ext_first_tick", count_tick2, 1'b1);
    check("ext_before_inc", counter_val2, 16'h0);
    step(1);
    check("ext_first_inc", counter_val2, 16'h1);
    ext_clk2 = 1'b1;
    step(4);
    for (int p = 0; p < 9; p++) begin
      ext_clk2 = 1'b0;
      step(4);
      ext_clk2 = 1'b1;
      step(4);
    end
    step(6);
    check("ext_count10", counter_val2, 16'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
